fetch_unit: RTL and testbench

- Instruction-fetch (IF) stage. Sits directly upstream of the IF/ID stage register.
- Generates fetch addresses and runs a req/ack handshake to a variable-latency instruction memory.
- Buffers returned words in a small FIFO and presents {ins, next_pc} to the IF/ID register.
- Handles stall from decode and PC redirects (branch/jump) from the MEM stage.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues word fetches over a req/ack handshake,
// buffers returned words in a small FIFO and presents {ins, next_pc} to IF/ID.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ISSUE   | no request pending; raise a new request if a slot is free
//   WAIT    | request issued, not yet acknowledged; hold req/addr
//   DISCARD | redirect hit a pending request; hold it, drop its data
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_ins,
    output logic [31:0] out_next_pc,
    output logic [31:0] fetch_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     ins_mem [DEPTH];
    logic [31:0]     npc_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            pending;
    logic            push;
    logic            pop;
    logic [31:0]     pc_plus4;
    logic [31:0]     redirect_tgt;
    logic [31:0]     fetch_pc_nxt;
    logic [CW-1:0]   count_nxt;

    assign pending      = imem_req && !imem_ack;
    assign push         = imem_req && imem_ack && (state != DISCARD) && !redirect;
    assign pop          = out_valid && !stall && !redirect;
    assign pc_plus4     = fetch_pc + 32'd4;
    assign redirect_tgt = redirect_pc & ~32'd3;

    always_comb begin
        count_nxt    = count;
        fetch_pc_nxt = fetch_pc;
        if (redirect) begin
            count_nxt    = '0;
            fetch_pc_nxt = redirect_tgt;
        end else begin
            count_nxt = count + CW'(push) - CW'(pop);
            if (push) begin
                fetch_pc_nxt = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ISSUE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            fetch_pc <= fetch_pc_nxt;
            count    <= count_nxt;

            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end

            // A pending request keeps req/addr untouched regardless of redirect.
            if (pending) begin
                if (redirect) begin
                    state <= DISCARD;
                end else if (state == ISSUE) begin
                    state <= WAIT;
                end
            end else begin
                state     <= ISSUE;
                imem_req  <= (count_nxt < CW'(DEPTH));
                imem_addr <= fetch_pc_nxt;
            end
        end
    end

    // Entry storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            ins_mem[wr_ptr] <= imem_rdata;
            npc_mem[wr_ptr] <= pc_plus4;
        end
    end

    assign out_valid   = (count != '0);
    assign out_ins     = out_valid ? ins_mem[rd_ptr] : 32'd0;
    assign out_next_pc = out_valid ? npc_mem[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with programmable ack latency
// and a scoreboard queue of expected {ins, next_pc} entries.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_ins;
    logic [31:0] out_next_pc;
    logic [31:0] fetch_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ins    (out_ins),
        .out_next_pc(out_next_pc),
        .fetch_pc   (fetch_pc)
    );

    int          checks   = 0;
    int          failures = 0;
    int          lat      = 1;
    int          wait_cnt = 0;
    int          acks     = 0;
    logic [63:0] sb [$];
    logic        drop;
    logic [31:0] exp_pc;
    logic        prev_pend;
    logic [31:0] prev_addr;
    logic        found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        drop      = 1'b0;
        exp_pc    = RST_PC;
        prev_pend = 1'b0;
        prev_addr = RST_PC;
        wait_cnt  = 0;
        imem_ack  = 1'b0;
    endtask

    // One clock cycle: memory response, output checks, model commit.
    task automatic tick();
        logic [63:0] head;
        @(negedge clk);
        imem_ack = 1'b0;
        if (imem_req) begin
            if (wait_cnt >= lat - 1) begin
                imem_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        imem_rdata = imem_addr ^ 32'hA5A5_0000;

        if (prev_pend) begin
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, prev_addr);
        end else if (imem_req) begin
            chk("req_addr", imem_addr, exp_pc);
        end
        chk("fetch_pc", fetch_pc, exp_pc);
        chk("occupancy", 32'((sb.size() + int'(imem_req)) <= DEPTH), 32'd1);
        if (sb.size() > 0) begin
            head = sb[0];
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_ins", out_ins, head[63:32]);
            chk("out_next_pc", out_next_pc, head[31:0]);
        end else begin
            chk("out_valid_idle", 32'(out_valid), 32'd0);
            chk("out_ins_idle", out_ins, 32'd0);
            chk("out_next_pc_idle", out_next_pc, 32'd0);
        end

        if (redirect) begin
            sb.delete();
            drop   = imem_req && !imem_ack;
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (sb.size() > 0 && !stall) head = sb.pop_front();
            if (imem_req && imem_ack) begin
                if (drop) begin
                    drop = 1'b0;
                end else begin
                    sb.push_back({imem_rdata, imem_addr + 32'd4});
                    exp_pc = imem_addr + 32'd4;
                end
            end
        end
        if (imem_req && imem_ack) acks++;
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(imem_req), 32'd0);
        chk({tag, "_addr"}, imem_addr, RST_PC);
        chk({tag, "_fetch_pc"}, fetch_pc, RST_PC);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ins"}, out_ins, 32'd0);
        chk({tag, "_npc"}, out_next_pc, 32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_rdata  = 32'd0;
        lat         = 1;
        model_reset();
        #12;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Zero-wait memory: first data visible in cycle 2, addresses wrap.
        repeat (2) tick();
        chk("c2_valid", 32'(out_valid), 32'd1);
        chk("c2_ins", out_ins, 32'h5A5A_FFF8);
        chk("c2_npc", out_next_pc, 32'hFFFF_FFFC);
        chk("c2_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("c3_ins", out_ins, 32'h5A5A_FFFC);
        chk("c3_npc_wrap", out_next_pc, 32'h0000_0000);
        chk("c3_addr_wrap", imem_addr, 32'h0000_0000);
        tick();
        chk("c4_ins", out_ins, 32'hA5A5_0000);
        chk("c4_npc", out_next_pc, 32'h0000_0004);
        repeat (6) tick();

        // Stall: FIFO fills to DEPTH then requests stop; drain in order.
        stall = 1'b1;
        repeat (5) tick();
        chk("stall_req_off", 32'(imem_req), 32'd0);
        chk("stall_buffered", 32'(sb.size()), 32'(DEPTH));
        stall = 1'b0;
        repeat (6) tick();

        // Three-cycle ack latency: one instruction every three cycles.
        lat  = 3;
        acks = 0;
        repeat (12) tick();
        chk("lat3_acks", 32'(acks), 32'd4);

        // Redirect while the request to 0x10 sits in WAIT.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0010;
        tick();
        redirect = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && imem_addr == 32'h10 && prev_pend) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("wait_0x10_reached", 32'(found), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1002;
        tick();
        redirect = 1'b0;
        chk("redir_fetch_pc", fetch_pc, 32'h0000_1000);
        chk("redir_old_addr", imem_addr, 32'h0000_0010);
        chk("redir_valid", 32'(out_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req && imem_addr != 32'h10) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("redir_new_req_seen", 32'(found), 32'd1);
        chk("redir_new_addr", imem_addr, 32'h0000_1000);
        repeat (8) tick();

        // Redirect coinciding with ack and pop while FIFO+outstanding is full.
        lat = 1;
        repeat (5) tick();
        chk("full_pre_valid", 32'(out_valid), 32'd1);
        chk("full_pre_req", 32'(imem_req), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2000;
        tick();
        redirect = 1'b0;
        chk("full_redir_ack", 32'(imem_ack), 32'd1);
        chk("full_redir_valid", 32'(out_valid), 32'd0);
        chk("full_redir_req", 32'(imem_req), 32'd1);
        chk("full_redir_addr", imem_addr, 32'h0000_2000);
        repeat (5) tick();

        // Asynchronous reset in the middle of a WAIT.
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req && prev_pend) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("mid_wait_reached", 32'(found), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        model_reset();
        lat     = 1;
        reset_n = 1'b1;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
